// File: rtl/usart_pkg.sv
// Shared USART definitions: command codes and the TX-queue drain FSM states.
package usart_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_TX  = 3'd2
    } usart_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } drain_state_e;

    // A transmitter that never drops tx_ready is assumed to have taken the byte
    localparam int BUSY_TIMEOUT = 4;
    localparam int BUSY_CNT_W   = 2;
    localparam int OVF_CNT_W    = 8;

endpackage

// File: rtl/usart_tx_queue_if.sv
// Handshake between the TX queue (master) and usart_ctrl (slave).
interface usart_tx_queue_if #(
    parameter int DATA_WIDTH = 8
) ();
    import usart_pkg::*;

    logic                  usart_write;
    usart_cmd_e            usart_cmd;
    logic [DATA_WIDTH-1:0] usart_data;
    logic                  tx_ready;

    modport master (
        output usart_write,
        output usart_cmd,
        output usart_data,
        input  tx_ready
    );

    modport slave (
        input  usart_write,
        input  usart_cmd,
        input  usart_data,
        output tx_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is only taken
// when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/usart_tx_queue.sv
// CPU-to-USART transmit queue: edge-detected bus writes feed a FIFO that a
// small FSM drains into usart_ctrl. Define USART_TXQ_OVERFLOW_CNT_EN for a drop counter.
module usart_tx_queue #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_req,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
`ifdef USART_TXQ_OVERFLOW_CNT_EN
    output logic [7:0]             overflow_cnt,
`endif
    usart_tx_queue_if.master       usart_if
);
    import usart_pkg::*;

    logic                  r_wr_req_q;
    logic                  r_armed;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] r_usart_data;
    drain_state_e          r_state;
    drain_state_e          w_next_state;
    logic [BUSY_CNT_W-1:0] r_busy_cnt;
    logic                  w_usart_write;
    usart_cmd_e            w_usart_cmd;

    // r_armed masks the first cycle after reset so a wr_req already high is not an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_req_q <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_wr_req_q <= wr_req;
            r_armed    <= 1'b1;
        end
    end

    assign w_push = r_armed & wr_req & ~r_wr_req_q;

    sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (wr_data),
        .o_rdata (w_head),
        .o_full  (full),
        .o_empty (empty),
        .o_level (level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_busy_cnt   <= '0;
            r_usart_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state != WAIT_BUSY) r_busy_cnt <= '0;
            else                      r_busy_cnt <= r_busy_cnt + BUSY_CNT_W'(1);
            if (w_pop) r_usart_data <= w_head;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_usart_write = 1'b0;
        w_usart_cmd   = CMD_NOP;
        case (r_state)
            IDLE: begin
                if (!empty && usart_if.tx_ready) begin
                    w_pop        = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_usart_write = 1'b1;
                w_usart_cmd   = CMD_TX;
                w_next_state  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!usart_if.tx_ready)
                    w_next_state = WAIT_DONE;
                else if (r_busy_cnt == BUSY_CNT_W'(BUSY_TIMEOUT - 1))
                    w_next_state = IDLE;
            end
            WAIT_DONE: begin
                if (usart_if.tx_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign usart_if.usart_write = w_usart_write;
    assign usart_if.usart_cmd   = w_usart_cmd;
    assign usart_if.usart_data  = r_usart_data;

`ifdef USART_TXQ_OVERFLOW_CNT_EN
    logic                 w_drop;
    logic [OVF_CNT_W-1:0] r_overflow_cnt;

    assign w_drop = w_push & full & ~w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_overflow_cnt <= '0;
        else if (w_drop && (r_overflow_cnt != '1))
            r_overflow_cnt <= r_overflow_cnt + OVF_CNT_W'(1);
    end

    assign overflow_cnt = r_overflow_cnt;
`endif

endmodule

// File: doc/usart_tx_queue.md
USART_TX_QUEUE -- requirements
Module: usart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, byte width to USART.
REQ-003 SHALL have port clk  input  1  single clock, 16 MHz; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wr_req  input  1  bus-decoded write qualifier (level, high while CPU write active).
REQ-006 SHALL have port wr_data  input  DATA_WIDTH  byte from bus data path, valid while wr_req high.
REQ-007 SHALL have port tx_ready  input  1  USART transmitter idle (high = can accept byte).
REQ-008 SHALL have port usart_write  output  1  one-cycle strobe to usart_ctrl.
REQ-009 SHALL have port usart_cmd  output  3  command to usart_ctrl.
REQ-010 SHALL have port usart_data  output  DATA_WIDTH  byte to usart_ctrl.
REQ-011 SHALL have ports full, empty  output  1 each  FIFO status.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 SHALL register wr_req once (wr_req_q) and push wr_data exactly once per 0->1 edge of wr_req, in the edge cycle; a held-high wr_req SHALL NOT push again.
REQ-014 SHALL drop a push while full unless a pop occurs in the same cycle, in which case both occur and level is unchanged.
REQ-015 SHALL perform push and pop in the same cycle when non-empty, level unchanged.
REQ-016 SHALL wrap read/write pointers modulo DEPTH; full = (level==DEPTH), empty = (level==0).
REQ-017 SHALL run drain FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE -> ISSUE when !empty and tx_ready; pop occurs on this transition, head byte latched into usart_data.
REQ-019 ISSUE SHALL last exactly one cycle with usart_write=1, usart_cmd=CMD_TX (2); -> WAIT_BUSY.
REQ-020 WAIT_BUSY -> WAIT_DONE when tx_ready=0; -> IDLE if tx_ready stays 1 for 4 cycles (byte treated as accepted).
REQ-021 WAIT_DONE -> IDLE when tx_ready=1.
REQ-022 Outside ISSUE, usart_write SHALL be 0 and usart_cmd SHALL be CMD_NOP (0); usart_data SHALL hold last issued byte.
REQ-023 Latency: push into empty FIFO with tx_ready=1 -> usart_write asserted 2 cycles after the edge cycle.

Reset
REQ-024 reset_n low SHALL asynchronously clear pointers, level=0, empty=1, full=0, FSM=IDLE, usart_write=0, usart_cmd=0, usart_data=0, wr_req_q=0.
REQ-025 Reset mid-transfer SHALL discard queued bytes; no strobe SHALL be issued until a new push after release.
REQ-026 wr_req high at reset release SHALL NOT push (wr_req_q samples first).

Configuration
REQ-027 With USART_TXQ_OVERFLOW_CNT_EN defined, SHALL add output overflow_cnt (8 bits), incremented per dropped push, saturating at 255, cleared by reset.
REQ-028 Without USART_TXQ_OVERFLOW_CNT_EN, port and counter SHALL be absent; drops silent.

Structure
REQ-029 CMD_NOP, CMD_TX and the drain FSM state enum SHALL live in shared package usart_pkg, also used by usart_ctrl.
REQ-030 Storage and pointers SHALL be one sub-module sync_fifo (parameters DEPTH, DATA_WIDTH); FSM and edge detect stay in usart_tx_queue.

Verification
REQ-031 Reset, wr_req 0->1 with wr_data=0x41, tx_ready=1 -> usart_write one cycle, usart_cmd=2, usart_data=0x41, 2 cycles after edge; level back to 0.
REQ-032 wr_req held high 20 cycles with data 0x55 -> exactly one push, one strobe.
REQ-033 tx_ready=0, nine write edges with 0x01..0x09, DEPTH=8 -> full=1, level=8, 0x09 dropped (overflow_cnt=1 if enabled); release tx_ready, toggle per byte -> 0x01..0x08 emitted in order.
REQ-034 FIFO full, write edge in the same cycle as an IDLE->ISSUE pop -> byte accepted, level stays 8.
REQ-035 Three bytes queued, reset_n pulsed low during WAIT_DONE -> empty=1, no further usart_write.
REQ-036 tx_ready held 1 after ISSUE -> FSM returns to IDLE after 4 cycles; next byte issued.
